key_decoder: RTL and testbench
==============================

KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, ASCII queue depth (power of two).
REQ-002 clk  input  1  system clock; all logic samples on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 code_valid  input  1  one-cycle strobe: code holds a complete PS/2 set-2 byte from the receiver.
REQ-005 code  input  8  raw scancode byte.
REQ-006 pop  input  1  consumer removes head entry this cycle.
REQ-007 clear_ovf  input  1  clears the overflow flag.
REQ-008 ascii  output  8  head-of-queue character (show-ahead); 8'h00 when empty.
REQ-009 ready  output  1  queue non-empty.
REQ-010 key_status  output  8  {4'b0, overflow, caps, shift, last_was_break}.

Function
REQ-011 Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0); advances only on code_valid.
REQ-012 IDLE: E0 -> EXT; F0 -> BRK; other byte = make code, processed, stay IDLE.
REQ-013 EXT: F0 -> EXT_BRK; E0 -> EXT; other byte = extended make, processed, -> IDLE.
REQ-014 BRK: any byte = break code, processed, -> IDLE; EXT_BRK: any byte = extended break, processed, -> IDLE.
REQ-015 Shift: make of 12 or 59 sets the respective held bit, break clears it; shift = OR of both bits.
REQ-016 Caps: make of 58 toggles caps only when caps_held is 0, then sets caps_held; break of 58 clears caps_held (typematic repeats do not toggle).
REQ-017 Non-extended make codes translate via fixed table: letters 1C..1A per set 2 to 'a'..'z', uppercase when shift XOR caps; digits 45,16,1E,26,25,2E,36,3D,3E,46 to '0'..'9', with shifted US symbols when shift; 29->20, 5A->0D, 66->08, 0D->09, 76->1B.
REQ-018 Extended make codes 75,72,6B,74 translate to 80,81,82,83 (up, down, left, right); all other extended codes produce nothing.
REQ-019 Break codes, modifier makes, prefixes and untranslated codes never push to the queue.
REQ-020 Push latency: code_valid in cycle N with translatable make -> entry written at edge ending N, ready/ascii reflect it in cycle N+1.
REQ-021 last_was_break updates on every processed (non-prefix) byte: 1 for break, 0 for make.
REQ-022 pop when empty is ignored; pop when non-empty advances head at the edge, ascii shows next entry next cycle.
REQ-023 Push when full and no pop: character dropped, overflow set; overflow sticky until clear_ovf or rst.
REQ-024 Push and pop in same cycle: both performed, count unchanged, including when full (no overflow).
REQ-025 clear_ovf and a dropping push in the same cycle: overflow ends set.
REQ-026 Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-027 rst: FSM -> IDLE; shift bits, caps, caps_held, overflow, last_was_break -> 0; pointers and count -> 0; ready=0, ascii=00, key_status=00.
REQ-028 rst mid-prefix (e.g. after E0) discards the prefix; the next byte is decoded from IDLE.
REQ-029 rst takes priority over code_valid, pop and clear_ovf in the same cycle.

Structure
REQ-030 Shared package key_pkg holds: prefix constants E0/F0, modifier scancodes 12/59/58, FSM state enum, arrow code constants, scancode-to-ASCII translation function.
REQ-031 The queue is a separate sub-module key_fifo (synchronous, show-ahead, push/pop/full/empty/count); key_decoder instantiates it once.

Verification
REQ-032 Bytes 1C -> ascii=61 ('a'), ready=1 next cycle; pop -> ready=0, ascii=00.
REQ-033 Bytes 12, 1C, F0 1C, F0 12, 1C -> queue holds 41, 61; key_status bit1 clear at end, bit0=0.
REQ-034 Bytes 58, 58, F0 58, 1C -> caps=1 (single toggle), queued 41; then 58, F0 58, 1C -> caps=0, queued 61.
REQ-035 Bytes E0 75, E0 F0 75, E0 11 -> exactly one entry 80; FSM in IDLE afterward.
REQ-036 Nine makes of 1C, no pop -> 8 entries of 61, overflow=1 (key_status=08); simultaneous push+pop when full -> count 8, overflow unchanged; clear_ovf -> key_status=00.
REQ-037 Byte E0, rst one cycle, byte 75 -> nothing queued (75 untranslated from IDLE), all outputs 00 after rst.

Source files
------------

// File: rtl/key_pkg.sv
// Shared PS/2 set-2 constants, prefix FSM state type and the scancode-to-character map
// used by the keyboard decoder.
package key_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] KEY_UP    = 8'h80;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_LEFT  = 8'h82;
  localparam logic [7:0] KEY_RIGHT = 8'h83;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
  } xlat_t;

  // Letters are emitted lowercase and folded to uppercase afterwards when shift XOR caps.
  function automatic xlat_t translate(input logic [7:0] sc, input logic ext,
                                      input logic shift, input logic caps);
    xlat_t r;
    logic  alpha;
    r.hit = 1'b1;
    r.ch  = 8'h00;
    alpha = 1'b0;
    if (ext) begin
      case (sc)
        SC_UP:    r.ch = KEY_UP;
        SC_DOWN:  r.ch = KEY_DOWN;
        SC_LEFT:  r.ch = KEY_LEFT;
        SC_RIGHT: r.ch = KEY_RIGHT;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (sc)
        8'h1C: begin r.ch = 8'h61; alpha = 1'b1; end
        8'h32: begin r.ch = 8'h62; alpha = 1'b1; end
        8'h21: begin r.ch = 8'h63; alpha = 1'b1; end
        8'h23: begin r.ch = 8'h64; alpha = 1'b1; end
        8'h24: begin r.ch = 8'h65; alpha = 1'b1; end
        8'h2B: begin r.ch = 8'h66; alpha = 1'b1; end
        8'h34: begin r.ch = 8'h67; alpha = 1'b1; end
        8'h33: begin r.ch = 8'h68; alpha = 1'b1; end
        8'h43: begin r.ch = 8'h69; alpha = 1'b1; end
        8'h3B: begin r.ch = 8'h6A; alpha = 1'b1; end
        8'h42: begin r.ch = 8'h6B; alpha = 1'b1; end
        8'h4B: begin r.ch = 8'h6C; alpha = 1'b1; end
        8'h3A: begin r.ch = 8'h6D; alpha = 1'b1; end
        8'h31: begin r.ch = 8'h6E; alpha = 1'b1; end
        8'h44: begin r.ch = 8'h6F; alpha = 1'b1; end
        8'h4D: begin r.ch = 8'h70; alpha = 1'b1; end
        8'h15: begin r.ch = 8'h71; alpha = 1'b1; end
        8'h2D: begin r.ch = 8'h72; alpha = 1'b1; end
        8'h1B: begin r.ch = 8'h73; alpha = 1'b1; end
        8'h2C: begin r.ch = 8'h74; alpha = 1'b1; end
        8'h3C: begin r.ch = 8'h75; alpha = 1'b1; end
        8'h2A: begin r.ch = 8'h76; alpha = 1'b1; end
        8'h1D: begin r.ch = 8'h77; alpha = 1'b1; end
        8'h22: begin r.ch = 8'h78; alpha = 1'b1; end
        8'h35: begin r.ch = 8'h79; alpha = 1'b1; end
        8'h1A: begin r.ch = 8'h7A; alpha = 1'b1; end
        8'h45: r.ch = shift ? 8'h29 : 8'h30;
        8'h16: r.ch = shift ? 8'h21 : 8'h31;
        8'h1E: r.ch = shift ? 8'h40 : 8'h32;
        8'h26: r.ch = shift ? 8'h23 : 8'h33;
        8'h25: r.ch = shift ? 8'h24 : 8'h34;
        8'h2E: r.ch = shift ? 8'h25 : 8'h35;
        8'h36: r.ch = shift ? 8'h5E : 8'h36;
        8'h3D: r.ch = shift ? 8'h26 : 8'h37;
        8'h3E: r.ch = shift ? 8'h2A : 8'h38;
        8'h46: r.ch = shift ? 8'h28 : 8'h39;
        8'h29: r.ch = 8'h20;
        8'h5A: r.ch = 8'h0D;
        8'h66: r.ch = 8'h08;
        8'h0D: r.ch = 8'h09;
        8'h76: r.ch = 8'h1B;
        default: r.hit = 1'b0;
      endcase
      if (alpha && (shift ^ caps)) r.ch = r.ch - 8'h20;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_decoder_if.sv
// Scancode input, consumer pop/clear controls and character-queue outputs of the decoder.
interface key_decoder_if;
  logic       code_valid;
  logic [7:0] code;
  logic       pop;
  logic       clear_ovf;
  logic [7:0] ascii;
  logic       ready;
  logic [7:0] key_status;

  modport master (
    output code_valid, code, pop, clear_ovf,
    input  ascii, ready, key_status
  );

  modport slave (
    input  code_valid, code, pop, clear_ovf,
    output ascii, ready, key_status
  );
endinterface

// File: rtl/key_fifo.sv
// Synchronous show-ahead queue; a push into a full queue is accepted only alongside a pop.
module key_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty masks stale contents on dout.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/key_decoder.sv
// PS/2 set-2 decoder: prefix FSM, shift/caps tracking, translation to characters and a
// show-ahead character queue with a sticky overflow flag.
module key_decoder
  import key_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  key_decoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  state_e      state_q, state_d;
  logic        proc, is_brk, is_ext;
  logic        shift_l_q, shift_r_q, caps_q, caps_held_q, overflow_q, last_brk_q;
  logic        shift;
  xlat_t       xlat;
  logic        push_req, drop;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic [7:0]  fifo_dout;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // proc marks a non-prefix byte that completes a make or break sequence.
  always_comb begin
    state_d = state_q;
    proc    = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    if (bus.code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.code == SC_EXT)      state_d = ST_EXT;
          else if (bus.code == SC_BRK) state_d = ST_BRK;
          else                         proc = 1'b1;
        end
        ST_EXT: begin
          if (bus.code == SC_BRK)      state_d = ST_EXT_BRK;
          else if (bus.code == SC_EXT) state_d = ST_EXT;
          else begin
            proc    = 1'b1;
            is_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          proc    = 1'b1;
          is_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          proc    = 1'b1;
          is_brk  = 1'b1;
          is_ext  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign shift    = shift_l_q | shift_r_q;
  assign xlat     = translate(bus.code, is_ext, shift, caps_q);
  assign push_req = proc & ~is_brk & xlat.hit;
  // A pop against a full queue always frees a slot, so only a pop-less push drops.
  assign drop     = push_req & fifo_full & ~bus.pop;

  // Extended variants of the modifier codes (e.g. E0 12) are not treated as modifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
      last_brk_q  <= 1'b0;
    end else begin
      if (drop)               overflow_q <= 1'b1;
      else if (bus.clear_ovf) overflow_q <= 1'b0;
      if (proc) begin
        last_brk_q <= is_brk;
        if (!is_ext) begin
          case (bus.code)
            SC_LSHIFT: shift_l_q <= ~is_brk;
            SC_RSHIFT: shift_r_q <= ~is_brk;
            SC_CAPS: begin
              if (is_brk) begin
                caps_held_q <= 1'b0;
              end else begin
                if (!caps_held_q) caps_q <= ~caps_q;
                caps_held_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  key_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (xlat.ch),
    .pop   (bus.pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.ascii      = fifo_dout;
  assign bus.ready      = ~fifo_empty;
  assign bus.key_status = {4'b0000, overflow_q, caps_q, shift, last_brk_q};

  a_count_consistent: assert property (@(posedge clk) disable iff (rst)
    (fifo_count <= FULL_CNT) && ((fifo_count == FULL_CNT) == fifo_full));

endmodule

// File: tb/tb_key_decoder.sv
// Scenario bench for key_decoder: expected characters are queued as bytes are sent and
// compared against ascii/ready while the bench pops the DUT queue.
module tb_key_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_decoder_if bus();

  key_decoder #(.FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] sb[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
  logic [7:0] digit_sc  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46};
  logic [7:0] digit_sym [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                 8'h2A, 8'h28};

  // All tasks start and end on a falling edge; inputs change there, outputs are read there.
  task automatic send(input logic [7:0] b);
    bus.code_valid = 1'b1;
    bus.code       = b;
    @(negedge clk);
    bus.code_valid = 1'b0;
    bus.code       = 8'h00;
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [7:0] ch);
    sb.push_back(ch);
    send(b);
  endtask

  task automatic drain(input string tag);
    logic [7:0] exp;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      n_checks++;
      if (bus.ready !== 1'b1 || bus.ascii !== exp) begin
        n_errors++;
        $display("FAIL %s: ready=%0b ascii=%02h, expected ready=1 ascii=%02h",
                 tag, bus.ready, bus.ascii, exp);
      end
      bus.pop = 1'b1;
      @(negedge clk);
      bus.pop = 1'b0;
    end
    n_checks++;
    if (bus.ready !== 1'b0 || bus.ascii !== 8'h00) begin
      n_errors++;
      $display("FAIL %s_empty: ready=%0b ascii=%02h, expected ready=0 ascii=00",
               tag, bus.ready, bus.ascii);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.code_valid = 1'b0; bus.code = 8'h00; bus.pop = 1'b0; bus.clear_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.ascii !== 8'h00) begin n_errors++; $display("FAIL reset_ascii: got %02h expected 00", bus.ascii); end
    n_checks++;
    if (bus.ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %0b expected 0", bus.ready); end
    n_checks++;
    if (bus.key_status !== 8'h00) begin n_errors++; $display("FAIL reset_status: got %02h expected 00", bus.key_status); end
  endtask

  task automatic test_basic();
    send_exp(8'h1C, 8'h61);
    n_checks++;
    if (bus.ready !== 1'b1) begin n_errors++; $display("FAIL basic_latency: ready=%0b expected 1", bus.ready); end
    drain("basic");
  endtask

  task automatic test_shift();
    send(8'h12);
    send_exp(8'h1C, 8'h41);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    send_exp(8'h1C, 8'h61);
    n_checks++;
    if (bus.key_status !== 8'h00) begin n_errors++; $display("FAIL shift_status: got %02h expected 00", bus.key_status); end
    drain("shift");
  endtask

  task automatic test_caps();
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    n_checks++;
    if (bus.key_status !== 8'h05) begin n_errors++; $display("FAIL caps_on_status: got %02h expected 05", bus.key_status); end
    send_exp(8'h1C, 8'h41);
    n_checks++;
    if (bus.key_status !== 8'h04) begin n_errors++; $display("FAIL caps_make_status: got %02h expected 04", bus.key_status); end
    drain("caps_on");
    send(8'h12);
    send_exp(8'h1C, 8'h61);
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58);
    send_exp(8'h1C, 8'h61);
    n_checks++;
    if (bus.key_status !== 8'h00) begin n_errors++; $display("FAIL caps_off_status: got %02h expected 00", bus.key_status); end
    drain("caps_off");
  endtask

  task automatic test_ext();
    send(8'hE0); send_exp(8'h75, 8'h80);
    send(8'hE0); send(8'hF0); send(8'h75);
    n_checks++;
    if (bus.key_status !== 8'h01) begin n_errors++; $display("FAIL ext_break_status: got %02h expected 01", bus.key_status); end
    send(8'hE0); send(8'h11);
    n_checks++;
    if (bus.key_status !== 8'h00) begin n_errors++; $display("FAIL ext_make_status: got %02h expected 00", bus.key_status); end
    drain("ext_one");
    send(8'hE0); send(8'hE0); send_exp(8'h72, 8'h81);
    send(8'hE0); send_exp(8'h6B, 8'h82);
    send(8'hE0); send_exp(8'h74, 8'h83);
    send(8'hE0); send(8'h1C);
    send_exp(8'h1C, 8'h61);
    drain("ext_arrows");
  endtask

  task automatic test_table();
    for (int i = 0; i < 26; i++) begin
      send_exp(letter_sc[i], 8'(8'h61 + i));
      drain("letter");
    end
    for (int i = 0; i < 10; i++) begin
      send_exp(digit_sc[i], 8'(8'h30 + i));
      drain("digit");
    end
    send(8'h59);
    for (int i = 0; i < 26; i++) begin
      send_exp(letter_sc[i], 8'(8'h41 + i));
      drain("letter_shift");
    end
    for (int i = 0; i < 10; i++) begin
      send_exp(digit_sc[i], digit_sym[i]);
      drain("digit_shift");
    end
    send(8'hF0); send(8'h59);
    send_exp(8'h29, 8'h20); send_exp(8'h5A, 8'h0D); send_exp(8'h66, 8'h08);
    send_exp(8'h0D, 8'h09); send_exp(8'h76, 8'h1B);
    drain("misc");
    send(8'h05); send(8'h11); send(8'hF0); send(8'h1C); send(8'h75);
    drain("untranslated");
  endtask

  task automatic test_pop_empty();
    bus.pop = 1'b1;
    repeat (2) @(negedge clk);
    bus.pop = 1'b0;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.ascii !== 8'h00) begin
      n_errors++; $display("FAIL pop_empty: ready=%0b ascii=%02h expected 0/00", bus.ready, bus.ascii);
    end
    send_exp(8'h1C, 8'h61);
    send_exp(8'h32, 8'h62);
    drain("pop_empty_after");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) send_exp(8'h1C, 8'h61);
    n_checks++;
    if (bus.key_status !== 8'h00) begin n_errors++; $display("FAIL full_status: got %02h expected 00", bus.key_status); end
    send(8'h1C);
    n_checks++;
    if (bus.key_status !== 8'h08) begin n_errors++; $display("FAIL ovf_status: got %02h expected 08", bus.key_status); end
    n_checks++;
    if (bus.ascii !== 8'h61) begin n_errors++; $display("FAIL full_head: got %02h expected 61", bus.ascii); end
    void'(sb.pop_front());
    sb.push_back(8'h62);
    bus.pop = 1'b1;
    send(8'h32);
    bus.pop = 1'b0;
    n_checks++;
    if (bus.key_status !== 8'h08) begin n_errors++; $display("FAIL push_pop_full_status: got %02h expected 08", bus.key_status); end
    bus.clear_ovf = 1'b1;
    @(negedge clk);
    bus.clear_ovf = 1'b0;
    n_checks++;
    if (bus.key_status !== 8'h00) begin n_errors++; $display("FAIL clear_ovf: got %02h expected 00", bus.key_status); end
    bus.clear_ovf = 1'b1;
    send(8'h1C);
    bus.clear_ovf = 1'b0;
    n_checks++;
    if (bus.key_status !== 8'h08) begin n_errors++; $display("FAIL clear_vs_drop: got %02h expected 08", bus.key_status); end
    bus.clear_ovf = 1'b1;
    @(negedge clk);
    bus.clear_ovf = 1'b0;
    drain("overflow");
  endtask

  task automatic test_rst_prefix();
    send(8'h12);
    send(8'h1C);
    n_checks++;
    if (bus.key_status !== 8'h02 || bus.ready !== 1'b1) begin
      n_errors++; $display("FAIL pre_rst: status=%02h ready=%0b expected 02/1", bus.key_status, bus.ready);
    end
    send(8'hE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.key_status !== 8'h00 || bus.ready !== 1'b0 || bus.ascii !== 8'h00) begin
      n_errors++; $display("FAIL rst_outputs: status=%02h ready=%0b ascii=%02h expected 00/0/00",
                           bus.key_status, bus.ready, bus.ascii);
    end
    send(8'h75);
    drain("rst_prefix");
    send(8'h1C);
    rst = 1'b1;
    bus.code_valid = 1'b1; bus.code = 8'h1C; bus.clear_ovf = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.code_valid = 1'b0; bus.code = 8'h00; bus.clear_ovf = 1'b0;
    drain("rst_priority");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_caps();
    test_ext();
    test_table();
    test_pop_empty();
    test_overflow();
    test_rst_prefix();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
